// File: rtl/tt_um_mult_ctrl.sv
// Sequencing controller for a two-element-per-beat matrix-vector MAC datapath.
// Clears accumulators, steps input beats, then drains output rows one by one.
module tt_um_mult_ctrl #(
   parameter int unsigned MaxInLen  = 16,
   parameter int unsigned MaxOutLen = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [4:0] cfg_in_len,
   input  logic [3:0] cfg_out_len,
   input  logic       vec_valid,
   output logic       vec_ready,
   output logic       mac_clr,
   output logic       mac_en,
   output logic [3:0] mac_row,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_sel,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MaxBeats = MaxInLen / 2;
   localparam int unsigned BeatW    = $clog2(MaxBeats + 1);
   localparam int unsigned RowW     = $clog2(MaxOutLen + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      DONE
   } state_e;

   state_e            state_q;
   logic [BeatW-1:0]  beat_q;
   logic [BeatW-1:0]  beats_q;
   logic [RowW-1:0]   row_q;
   logic [RowW-1:0]   rows_q;

   logic [5:0]        half_len;
   logic [BeatW-1:0]  beats_cfg;
   logic [RowW-1:0]   rows_cfg;

   // Clamp the requested lengths so the counters' terminal counts stay in range.
   assign half_len = (6'(cfg_in_len) + 6'd1) >> 1;

   always_comb begin
      beats_cfg = BeatW'(half_len);
      if (half_len == 6'd0) begin
         beats_cfg = BeatW'(1);
      end else if (half_len > 6'(MaxBeats)) begin
         beats_cfg = BeatW'(MaxBeats);
      end

      rows_cfg = RowW'(cfg_out_len);
      if (cfg_out_len == 4'd0) begin
         rows_cfg = RowW'(1);
      end else if (5'(cfg_out_len) > 5'(MaxOutLen)) begin
         rows_cfg = RowW'(MaxOutLen);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         row_q   <= '0;
         beats_q <= BeatW'(1);
         rows_q  <= RowW'(1);
      end else if (abort) begin
         state_q <= IDLE;
         beat_q  <= '0;
         row_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  beats_q <= beats_cfg;
                  rows_q  <= rows_cfg;
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
               beat_q  <= '0;
               row_q   <= '0;
               state_q <= ACCUM;
            end
            ACCUM: begin
               if (vec_valid) begin
                  if (beat_q == beats_q - BeatW'(1)) begin
                     beat_q  <= '0;
                     state_q <= DRAIN;
                  end else begin
                     beat_q <= beat_q + BeatW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row_q == rows_q - RowW'(1)) begin
                     row_q   <= '0;
                     state_q <= DONE;
                  end else begin
                     row_q <= row_q + RowW'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode the state register; abort masks the action strobes in its cycle.
   assign vec_ready = (state_q == ACCUM);
   assign mac_en    = vec_valid & vec_ready & ~abort;
   assign mac_clr   = (state_q == CLEAR) & ~abort;
   assign done      = (state_q == DONE) & ~abort;
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != IDLE);
   assign mac_row   = 4'({beat_q, 1'b0});
   assign out_sel   = 3'(row_q);

endmodule

// File: tb/tb_tt_um_mult_ctrl.sv
// Self-checking bench for tt_um_mult_ctrl: scripted and randomized operations
// checked against a transaction-level expectation of beats, rows and done.
module tb_tt_um_mult_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [4:0] cfg_in_len;
   logic [3:0] cfg_out_len;
   logic       vec_valid;
   logic       vec_ready;
   logic       mac_clr;
   logic       mac_en;
   logic [3:0] mac_row;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_sel;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   tt_um_mult_ctrl #(.MaxInLen(16), .MaxOutLen(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
      .vec_valid(vec_valid), .vec_ready(vec_ready),
      .mac_clr(mac_clr), .mac_en(mac_en), .mac_row(mac_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags order: busy, vec_ready, mac_clr, mac_en, out_valid, done
   function automatic logic [5:0] flags();
      return {busy, vec_ready, mac_clr, mac_en, out_valid, done};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation from an IDLE cycle with start=1 through DONE and back to IDLE.
   task automatic run_op(input int in_len, input int out_len, input int vpct,
                         input int rpct, input bit pat, input bit hold_start);
      int b, r, k, j, i;
      b = (in_len + 1) / 2;
      if (b < 1) b = 1;
      if (b > 8) b = 8;
      r = out_len;
      if (r < 1) r = 1;
      if (r > 8) r = 8;

      start = 1'b1; abort = 1'b0; vec_valid = 1'b0; out_ready = 1'b0;
      cfg_in_len = 5'(in_len); cfg_out_len = 4'(out_len);
      #2;
      n_cmp++;
      if (flags() !== 6'b000000) begin
         n_bad++; $display("FAIL idle_flags got=%b want=000000", flags());
      end
      step();

      start = hold_start;
      cfg_in_len = 5'($urandom); cfg_out_len = 4'($urandom);
      vec_valid = 1'($urandom);
      #2;
      n_cmp++;
      if (flags() !== 6'b101000) begin
         n_bad++; $display("FAIL clear_flags got=%b want=101000", flags());
      end
      step();

      k = 0; i = 0;
      while (k < b && i < 200) begin
         vec_valid = pat ? 1'((i % 4 == 0) || (i % 4 == 3)) : 1'($urandom_range(99) < vpct);
         out_ready = 1'($urandom);
         cfg_in_len = 5'($urandom);
         #2;
         n_cmp++;
         if (flags() !== {4'b1100, 1'b0, 1'b0} + {3'b000, vec_valid, 2'b00}) begin
            n_bad++; $display("FAIL accum_flags beat=%0d got=%b valid=%b", k, flags(), vec_valid);
         end
         n_cmp++;
         if (mac_row !== 4'(2 * k)) begin
            n_bad++; $display("FAIL accum_row got=%0d want=%0d", mac_row, 2 * k);
         end
         if (vec_valid) k++;
         i++;
         step();
      end
      if (k < b) begin
         n_cmp++; n_bad++; $display("FAIL accum_timeout got=%0d beats want=%0d", k, b);
      end

      j = 0; i = 0;
      while (j < r && i < 200) begin
         out_ready = pat ? 1'(i >= 3) : 1'($urandom_range(99) < rpct);
         vec_valid = 1'($urandom);
         cfg_out_len = 4'($urandom);
         #2;
         n_cmp++;
         if (flags() !== 6'b100010) begin
            n_bad++; $display("FAIL drain_flags row=%0d got=%b want=100010", j, flags());
         end
         n_cmp++;
         if (out_sel !== 3'(j)) begin
            n_bad++; $display("FAIL drain_sel got=%0d want=%0d", out_sel, j);
         end
         if (out_ready) j++;
         i++;
         step();
      end
      if (j < r) begin
         n_cmp++; n_bad++; $display("FAIL drain_timeout got=%0d rows want=%0d", j, r);
      end

      vec_valid = 1'b0; out_ready = 1'b0;
      #2;
      n_cmp++;
      if (flags() !== 6'b100001) begin
         n_bad++; $display("FAIL done_flags got=%b want=100001", flags());
      end
      step();
      #2;
      n_cmp++;
      if (flags() !== 6'b000000) begin
         n_bad++; $display("FAIL post_idle got=%b want=000000", flags());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; vec_valid = 1'b1; out_ready = 1'b1;
      cfg_in_len = 5'd16; cfg_out_len = 4'd8;
      #3;
      n_cmp++;
      if ({flags(), mac_row, out_sel} !== 13'd0) begin
         n_bad++; $display("FAIL reset_outs got=%b want=0", {flags(), mac_row, out_sel});
      end
      #19 rst = 1'b0;
      vec_valid = 1'b0; out_ready = 1'b0;
      step();
      #2;
      n_cmp++;
      if (flags() !== 6'b000000) begin
         n_bad++; $display("FAIL reset_idle got=%b want=000000", flags());
      end
   endtask

   task automatic test_idle_abort();
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      #2;
      n_cmp++;
      if (flags() !== 6'b000000) begin
         n_bad++; $display("FAIL idle_abort got=%b want=000000", flags());
      end
   endtask

   task automatic test_abort_accum();
      start = 1'b1; cfg_in_len = 5'd16; cfg_out_len = 4'd8;
      step();
      start = 1'b0;
      step();
      vec_valid = 1'b1;
      repeat (3) step();
      abort = 1'b1;
      #2;
      n_cmp++;
      if ({mac_en, mac_clr, done, mac_row} !== {3'b000, 4'd6}) begin
         n_bad++; $display("FAIL abort_cycle got=%b want=0000110", {mac_en, mac_clr, done, mac_row});
      end
      step();
      abort = 1'b0; vec_valid = 1'b0;
      #2;
      n_cmp++;
      if ({flags(), mac_row} !== 10'd0) begin
         n_bad++; $display("FAIL abort_idle got=%b want=0", {flags(), mac_row});
      end
      run_op(16, 8, 100, 100, 1'b0, 1'b0);
   endtask

   task automatic test_reset_drain();
      start = 1'b1; cfg_in_len = 5'd4; cfg_out_len = 4'd4;
      step();
      start = 1'b0; vec_valid = 1'b1;
      repeat (3) step();
      out_ready = 1'b1;
      step();
      #2;
      n_cmp++;
      if ({out_valid, out_sel} !== 4'b1001) begin
         n_bad++; $display("FAIL drain_pre got=%b want=1001", {out_valid, out_sel});
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({flags(), mac_row, out_sel} !== 13'd0) begin
         n_bad++; $display("FAIL async_reset got=%b want=0", {flags(), mac_row, out_sel});
      end
      #1 rst = 1'b0;
      start = 1'b1; vec_valid = 1'b0; out_ready = 1'b0;
      step();
      start = 1'b0;
      #2;
      n_cmp++;
      if (flags() !== 6'b101000) begin
         n_bad++; $display("FAIL reset_restart got=%b want=101000", flags());
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         run_op(int'($urandom_range(31)), int'($urandom_range(15)),
                int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_idle_abort();
      run_op(16, 8, 100, 100, 1'b0, 1'b0);   // continuous full-size timing
      run_op(5, 0, 100, 100, 1'b0, 1'b0);    // rounding up and zero-row clamp
      run_op(16, 8, 0, 0, 1'b1, 1'b0);       // valid 1,0,0,1 and ready stall
      test_abort_accum();
      test_reset_drain();
      run_op(7, 3, 100, 100, 1'b0, 1'b1);    // start held, cfg churn mid-run
      run_op(2, 2, 100, 100, 1'b0, 1'b0);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
